// File: rtl/uart_mmio.sv
// MMIO UART: DATA at offset 0, STATUS at offset 4. TX FIFO feeds an 8N1 serializer; RX has a synchronizer, deserializer and FIFO.
// Defining UART_PARITY_EN adds an even-parity bit to both directions. A write starts its start bit 2 cycles later; writes while tx_full and RX bytes arriving while the RX FIFO is full are dropped.

module uart_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] head_dat,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count, count_nxt;
  logic             do_push, do_pop;

  // A pop on a full FIFO frees the slot the simultaneous push writes into.
  assign do_pop   = pop_rdy && !empty;
  assign do_push  = push_vld && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop)      count_nxt = count + 1'b1;
    else if (do_pop && !do_push) count_nxt = count - 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
      full  <= (count_nxt == FULL_CNT);
      empty <= (count_nxt == '0);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module uart_mmio #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_wen,
  input  logic       rx_ren,
  input  logic [2:0] uart_addr,
  input  logic [7:0] uart_din,
  output logic [7:0] uart_dout,
  output logic       tx_full,
  output logic       rx_data_present,
  output logic       txd,
  input  logic       rxd
);
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BIT_LAST  = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(CLKS_PER_BIT / 2 - 1);

`ifdef UART_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} uart_state_e;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_e;
`endif

  typedef struct packed {
    logic [1:0] rsvd;
    logic       parity_err;
    logic       frame_err;
    logic       overrun;
    logic       tx_empty;
    logic       tx_full;
    logic       rx_data_present;
  } status_t;

  logic        is_data, is_stat, tx_push, rx_pop, stat_rd;
  logic        tx_fifo_empty, rx_fifo_full, rx_fifo_empty;
  logic [7:0]  tx_fifo_head, rx_fifo_head;
  status_t     status;

  assign is_data = (uart_addr == 3'd0);
  assign is_stat = (uart_addr == 3'd4);
  assign tx_push = tx_wen && is_data && !tx_full;
  assign rx_pop  = rx_ren && is_data;
  assign stat_rd = rx_ren && is_stat;

  // ---------------- TX ----------------
  uart_state_e   tx_state, tx_state_nxt;
  logic [BW-1:0] tx_cnt;
  logic [2:0]    tx_idx;
  logic [7:0]    tx_sh;
  logic          tx_tick, tx_pop;

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_tx_fifo (
    .clk(clk), .rst(rst), .push_vld(tx_push), .push_dat(uart_din), .pop_rdy(tx_pop),
    .head_dat(tx_fifo_head), .full(tx_full), .empty(tx_fifo_empty)
  );

  assign tx_tick = (tx_cnt == BIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) tx_state <= S_IDLE;
    else     tx_state <= tx_state_nxt;
  end

  always_comb begin
    tx_state_nxt = tx_state;
    case (tx_state)
      S_IDLE:   if (!tx_fifo_empty) tx_state_nxt = S_START;
      S_START:  if (tx_tick) tx_state_nxt = S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:   if (tx_tick && tx_idx == 3'd7) tx_state_nxt = S_PARITY;
      S_PARITY: if (tx_tick) tx_state_nxt = S_STOP;
`else
      S_DATA:   if (tx_tick && tx_idx == 3'd7) tx_state_nxt = S_STOP;
`endif
      S_STOP:   if (tx_tick) tx_state_nxt = S_IDLE;
      default:  tx_state_nxt = S_IDLE;
    endcase
  end

`ifdef UART_PARITY_EN
  logic tx_par;
`endif

  // txd is decoded from state so an asynchronous reset forces the line high at once.
  always_comb begin
    txd    = 1'b1;
    tx_pop = 1'b0;
    case (tx_state)
      S_IDLE:   tx_pop = !tx_fifo_empty;
      S_START:  txd = 1'b0;
      S_DATA:   txd = tx_sh[0];
`ifdef UART_PARITY_EN
      S_PARITY: txd = tx_par;
`endif
      default:  txd = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_cnt <= '0;
      tx_idx <= '0;
      tx_sh  <= '0;
`ifdef UART_PARITY_EN
      tx_par <= 1'b0;
`endif
    end else begin
      if (tx_state == S_IDLE || tx_tick) tx_cnt <= '0;
      else                               tx_cnt <= tx_cnt + 1'b1;
      if (tx_pop) begin
        tx_sh  <= tx_fifo_head;
        tx_idx <= '0;
`ifdef UART_PARITY_EN
        tx_par <= ^tx_fifo_head;
`endif
      end else if (tx_state == S_DATA && tx_tick) begin
        tx_sh  <= {1'b0, tx_sh[7:1]};
        tx_idx <= tx_idx + 1'b1;
      end
    end
  end

  // ---------------- RX ----------------
  uart_state_e   rx_state, rx_state_nxt;
  logic [1:0]    rx_sync;
  logic          rx_s, rx_prev;
  logic [BW-1:0] rx_cnt;
  logic [2:0]    rx_idx;
  logic [7:0]    rx_sh;
  logic          rx_tick, rx_half, rx_cnt_clr;
  logic          rx_push, frame_set, parity_set, overrun_set, rx_par_bad;
  logic          overrun, frame_err, parity_err;

  assign rx_s    = rx_sync[1];
  assign rx_tick = (rx_cnt == BIT_LAST);
  assign rx_half = (rx_cnt == HALF_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_sync <= 2'b11;
      rx_prev <= 1'b1;
    end else begin
      rx_sync <= {rx_sync[0], rxd};
      rx_prev <= rx_sync[1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rx_state <= S_IDLE;
    else     rx_state <= rx_state_nxt;
  end

  always_comb begin
    rx_state_nxt = rx_state;
    case (rx_state)
      S_IDLE:   if (rx_prev && !rx_s) rx_state_nxt = S_START;
      S_START:  if (rx_half) rx_state_nxt = rx_s ? S_IDLE : S_DATA;
`ifdef UART_PARITY_EN
      S_DATA:   if (rx_tick && rx_idx == 3'd7) rx_state_nxt = S_PARITY;
      S_PARITY: if (rx_tick) rx_state_nxt = S_STOP;
`else
      S_DATA:   if (rx_tick && rx_idx == 3'd7) rx_state_nxt = S_STOP;
`endif
      S_STOP:   if (rx_tick) rx_state_nxt = S_IDLE;
      default:  rx_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    rx_cnt_clr = 1'b0;
    rx_push    = 1'b0;
    frame_set  = 1'b0;
    parity_set = 1'b0;
    case (rx_state)
      S_IDLE:   rx_cnt_clr = 1'b1;
      S_START:  rx_cnt_clr = rx_half;
`ifdef UART_PARITY_EN
      S_PARITY: begin
        rx_cnt_clr = rx_tick;
        parity_set = rx_tick && (rx_s != ^rx_sh);
      end
`endif
      S_STOP: begin
        rx_cnt_clr = rx_tick;
        rx_push    = rx_tick && rx_s && !rx_par_bad;
        frame_set  = rx_tick && !rx_s;
      end
      default:  rx_cnt_clr = rx_tick;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_cnt <= '0;
      rx_idx <= '0;
      rx_sh  <= '0;
    end else begin
      if (rx_cnt_clr) rx_cnt <= '0;
      else            rx_cnt <= rx_cnt + 1'b1;
      if (rx_state == S_IDLE) begin
        rx_idx <= '0;
      end else if (rx_state == S_DATA && rx_tick) begin
        rx_sh  <= {rx_s, rx_sh[7:1]};
        rx_idx <= rx_idx + 1'b1;
      end
    end
  end

`ifdef UART_PARITY_EN
  // A bad parity bit only marks the byte; the stop bit is still checked before it is dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     rx_par_bad <= 1'b0;
    else if (rx_state == S_IDLE) rx_par_bad <= 1'b0;
    else if (parity_set)         rx_par_bad <= 1'b1;
  end
`else
  assign rx_par_bad = 1'b0;
`endif

  uart_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_rx_fifo (
    .clk(clk), .rst(rst), .push_vld(rx_push), .push_dat(rx_sh), .pop_rdy(rx_pop),
    .head_dat(rx_fifo_head), .full(rx_fifo_full), .empty(rx_fifo_empty)
  );

  assign overrun_set = rx_push && rx_fifo_full && !rx_pop;

  // Set beats clear when both land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun    <= 1'b0;
      frame_err  <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      overrun    <= overrun_set || (overrun && !stat_rd);
      frame_err  <= frame_set   || (frame_err && !stat_rd);
      parity_err <= parity_set  || (parity_err && !stat_rd);
    end
  end

  // ---------------- register read ----------------
  assign rx_data_present = !rx_fifo_empty;

  always_comb begin
    status                 = '0;
    status.parity_err      = parity_err;
    status.frame_err       = frame_err;
    status.overrun         = overrun;
    status.tx_empty        = tx_fifo_empty && (tx_state == S_IDLE);
    status.tx_full         = tx_full;
    status.rx_data_present = rx_data_present;
  end

  always_comb begin
    uart_dout = 8'h00;
    if (is_data)      uart_dout = rx_fifo_empty ? 8'h00 : rx_fifo_head;
    else if (is_stat) uart_dout = status;
  end
endmodule

// File: tb/tb_uart_mmio.sv
// Directed bench for uart_mmio at CLKS_PER_BIT=8, FIFO_DEPTH=16; a background monitor decodes txd into bytes.
`timescale 1ns/1ps
module tb_uart_mmio;
  localparam int CPB   = 8;
  localparam int DEPTH = 16;
`ifdef UART_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst, tx_wen, rx_ren, rxd;
  logic [2:0] uart_addr;
  logic [7:0] uart_din, uart_dout;
  logic       tx_full, rx_data_present, txd;

  int errors = 0;
  int checks = 0;
  logic [7:0] tx_q[$];
  logic       par_q[$];
  logic       exp_a5 [8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

  uart_mmio #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .tx_wen(tx_wen), .rx_ren(rx_ren), .uart_addr(uart_addr),
    .uart_din(uart_din), .uart_dout(uart_dout), .tx_full(tx_full),
    .rx_data_present(rx_data_present), .txd(txd), .rxd(rxd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] d);
    tx_wen = 1'b1; uart_addr = 3'd0; uart_din = d;
    tick(1);
    tx_wen = 1'b0;
  endtask

  task automatic rd_stat(input string tag, input logic [7:0] exp);
    rx_ren = 1'b1; uart_addr = 3'd4;
    #1 check(tag, 32'(uart_dout), 32'(exp));
    tick(1);
    rx_ren = 1'b0; uart_addr = 3'd0;
  endtask

  task automatic rd_data(input string tag, input logic [7:0] exp);
    rx_ren = 1'b1; uart_addr = 3'd0;
    #1 check(tag, 32'(uart_dout), 32'(exp));
    tick(1);
    rx_ren = 1'b0;
  endtask

  // Drives one serial frame; optionally issues a STATUS read in the cycle the DUT samples the stop bit.
  task automatic send_rx(input logic [7:0] d, input logic stop, input logic par_ok, input logic rd_at_stop);
    for (int b = 0; b < NB; b++) begin
      logic v;
      if (b == 0)           v = 1'b0;
      else if (b <= 8)      v = d[b-1];
      else if (b == NB - 1) v = stop;
      else                  v = (^d) ^ !par_ok;
      for (int k = 0; k < CPB; k++) begin
        rxd = v;
        if (rd_at_stop && b == NB - 1 && k == 6) begin
          rx_ren = 1'b1; uart_addr = 3'd4;
        end
        tick(1);
        rx_ren = 1'b0;
      end
    end
    rxd = 1'b1;
    tick(2);
  endtask

  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge txd);
      repeat (CPB / 2) @(posedge clk);
      #1;
      for (int i = 0; i < 8; i++) begin
        repeat (CPB) @(posedge clk);
        #1 b[i] = txd;
      end
`ifdef UART_PARITY_EN
      repeat (CPB) @(posedge clk);
      #1 par_q.push_back(txd);
`endif
      repeat (CPB) @(posedge clk);
      #1;
      if (!rst) check("tx_stop_bit", 32'(txd), 1);
      tx_q.push_back(b);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; tx_wen = 1'b0; rx_ren = 1'b0; uart_addr = 3'd0; uart_din = 8'h00; rxd = 1'b1;
    tick(3);
    check("rst_txd", 32'(txd), 1);
    check("rst_tx_full", 32'(tx_full), 0);
    check("rst_rx_dp", 32'(rx_data_present), 0);
    check("rst_dout", 32'(uart_dout), 0);
    uart_addr = 3'd4;
    #1 check("rst_status", 32'(uart_dout), 'h04);
    uart_addr = 3'd0;
    rst = 1'b0;
    tick(2);

    // TX of 0xA5: start bit at N+2, then bit centres every CPB cycles
    wr(8'hA5);
    check("tx_lat_n1", 32'(txd), 1);
    tick(1);
    check("tx_start_n2", 32'(txd), 0);
    uart_addr = 3'd4;
    #1 check("tx_busy_status", 32'(uart_dout), 'h00);
    uart_addr = 3'd0;
    tick(4);
    for (int i = 0; i < 8; i++) begin
      tick(CPB);
      check($sformatf("tx_a5_bit%0d", i), 32'(txd), 32'(exp_a5[i]));
    end
`ifdef UART_PARITY_EN
    tick(CPB);
    check("tx_a5_parity", 32'(txd), 0);
`endif
    tick(CPB);
    check("tx_a5_stop", 32'(txd), 1);
    tick(4);
    rd_stat("tx_empty_after", 8'h04);

    // Fill the TX FIFO while byte 0 is on the line, then overflow it
    tx_q.delete();
    for (int i = 0; i < 17; i++) begin
      tx_wen = 1'b1; uart_addr = 3'd0; uart_din = 8'(i);
      tick(1);
      if (i == 15) check("tx_not_full_16w", 32'(tx_full), 0);
    end
    check("tx_full_17w", 32'(tx_full), 1);
    uart_din = 8'h11; tick(1);
    uart_din = 8'h12; tick(1);
    tx_wen = 1'b0;
    check("tx_full_hold", 32'(tx_full), 1);
    rd_stat("tx_full_status", 8'h02);
    for (int t = 0; t < 4000 && tx_q.size() < 17; t++) tick(1);
    tick(200);
    check("tx_frame_count", 32'(tx_q.size()), 17);
    for (int i = 0; i < 17; i++)
      check($sformatf("tx_byte%0d", i), (i < tx_q.size()) ? 32'(tx_q[i]) : 32'hFFFF_FFFF, 32'(i));

    // Single RX frame
    send_rx(8'h3C, 1'b1, 1'b1, 1'b0);
    check("rx_dp_set", 32'(rx_data_present), 1);
    rd_data("rx_data_3c", 8'h3C);
    check("rx_dp_clr", 32'(rx_data_present), 0);
    rd_data("rx_empty_read", 8'h00);

    // Glitch, then a framing error
    rxd = 1'b0; tick(2);
    rxd = 1'b1; tick(40);
    check("glitch_no_push", 32'(rx_data_present), 0);
    rd_stat("glitch_status", 8'h04);
    send_rx(8'h55, 1'b0, 1'b1, 1'b0);
    check("frame_no_push", 32'(rx_data_present), 0);
    rd_stat("frame_err_set", 8'h14);
    rd_stat("frame_err_clr", 8'h04);

    // Overrun: 17 frames into a 16-deep FIFO
    for (int i = 0; i < 17; i++) send_rx(8'(8'h40 + i), 1'b1, 1'b1, 1'b0);
    rd_stat("overrun_set", 8'h0D);
    rd_stat("overrun_clr", 8'h05);
    send_rx(8'h60, 1'b1, 1'b1, 1'b1);
    rd_stat("overrun_set_wins", 8'h0D);
    rd_stat("overrun_clr2", 8'h05);
    for (int i = 0; i < 16; i++) rd_data($sformatf("rx_drain%0d", i), 8'(8'h40 + i));
    check("rx_drained", 32'(rx_data_present), 0);

`ifdef UART_PARITY_EN
    tx_q.delete();
    par_q.delete();
    wr(8'h07);
    for (int t = 0; t < 400 && tx_q.size() < 1; t++) tick(1);
    check("tx_par_07", (par_q.size() > 0) ? 32'(par_q[0]) : 32'hFFFF_FFFF, 1);
    check("tx_byte_07", (tx_q.size() > 0) ? 32'(tx_q[0]) : 32'hFFFF_FFFF, 'h07);
    tick(10);
    send_rx(8'h3C, 1'b1, 1'b0, 1'b0);
    check("par_no_push", 32'(rx_data_present), 0);
    rd_stat("parity_err_set", 8'h24);
    rd_stat("parity_err_clr", 8'h04);
`endif

    // Reset in the middle of a start bit returns txd high without a clock edge
    wr(8'h00);
    tick(3);
    check("pre_rst_txd", 32'(txd), 0);
    #2 rst = 1'b1;
    #1 check("mid_rst_txd", 32'(txd), 1);
    check("mid_rst_tx_full", 32'(tx_full), 0);
    tick(2);
    rst = 1'b0;
    tick(2);
    check("post_rst_txd", 32'(txd), 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
